// File: rtl/fp16_vec_accumulator.sv
// fp16_vec_accumulator: sequences VEC_LEN fp16 terms through an external adder into one sum.
// Optional sticky nan/inf flags are enabled with FP_ACC_FLAGS_EN.
module fp16_vec_accumulator #(
  parameter int VEC_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic [15:0] add_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
`ifdef FP_ACC_FLAGS_EN
  ,
  output logic        nan_flag,
  output logic        inf_flag
`endif
);
  typedef enum logic [1:0] {ACCEPT, ADD, OUT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
  state_t state_q, state_d;
  logic [15:0] acc_q, acc_d, opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last;
  assign last = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCEPT: if (in_valid) begin
        opnd_d  = in_data;
        state_d = ADD;
      end
      ADD: begin
        acc_d   = add_sum;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        state_d = last ? OUT : ACCEPT;
      end
      OUT: if (out_ready) begin
        acc_d   = '0;
        state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCEPT;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == ACCEPT;
  assign out_valid = state_q == OUT;
  assign out_data  = acc_q;
  assign add_a     = acc_q;
  assign add_b     = opnd_q;
  assign busy      = state_q != ACCEPT || cnt_q != '0;
`ifdef FP_ACC_FLAGS_EN
  logic nan_q, nan_d, inf_q, inf_d, take, sum_chk, clr;
  function automatic logic is_nan(input logic [15:0] v);
    return &v[14:10] && |v[9:0];
  endfunction
  function automatic logic is_inf(input logic [15:0] v);
    return &v[14:10] && ~|v[9:0];
  endfunction
  assign take    = state_q == ACCEPT && in_valid;
  assign sum_chk = state_q == ADD;
  assign clr     = state_q == OUT && out_ready;
  always_comb begin
    nan_d = clr ? 1'b0 : nan_q | (take && is_nan(in_data)) | (sum_chk && is_nan(add_sum));
    inf_d = clr ? 1'b0 : inf_q | (take && is_inf(in_data)) | (sum_chk && is_inf(add_sum));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      nan_q <= nan_d;
      inf_q <= inf_d;
    end
  end
  assign nan_flag = nan_q;
  assign inf_flag = inf_q;
`endif
endmodule

// File: tb/tb_fp16_vec_accumulator.sv
// tb_fp16_vec_accumulator: table vectors plus hand sequences, adder modelled in the bench.
module tb_fp16_vec_accumulator;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [15:0] in_data = '0, add_a, add_b, add_sum, out_data;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int e;
    e = int'(h[14:10]);
    m = real'({e != 0, h[9:0]});
    e = (e == 0 ? 1 : e) - 25;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction
  function automatic logic [15:0] r2h(input real r);
    logic s;
    int e;
    real m;
    s = r < 0.0;
    m = s ? -r : r;
    if (m == 0.0) return 16'h0000;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0 && e > 1) begin m = m * 2.0; e--; end
    if (e >= 31) return {s, 15'h7C00};
    if (m < 1.0) return {s, 5'd0, 10'($rtoi(m * 1024.0 + 0.5))};
    return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
  endfunction
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic an, bn, ai, bi;
    an = &a[14:10] && |a[9:0];
    bn = &b[14:10] && |b[9:0];
    ai = &a[14:10] && ~|a[9:0];
    bi = &b[14:10] && ~|b[9:0];
    if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7E00;
    if (ai) return a;
    if (bi) return b;
    return r2h(h2r(a) + h2r(b));
  endfunction
  assign add_sum = fp_add(add_a, add_b);

`ifdef FP_ACC_FLAGS_EN
  logic m_nan, m_inf;
`endif
  fp16_vec_accumulator #(.VEC_LEN(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef FP_ACC_FLAGS_EN
    , .nan_flag(m_nan), .inf_flag(m_inf)
`endif
  );

  typedef struct {logic [15:0] d; logic [15:0] m;} exp_t;
  typedef struct {logic [15:0] t [4]; logic [15:0] e; logic [15:0] m;} vec_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_result", 32'(out_data & x.m), 32'(x.d));
      end
    end
  end

  task automatic send(input logic [15:0] d, input int gap);
    int k;
    in_valid = 0;
    repeat (gap) tick();
    in_valid = 1;
    in_data  = d;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    if (k >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
  endtask
  task automatic send_vec(input vec_t v, input int gapmax);
    for (int i = 0; i < 4; i++) send(v.t[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    sb.push_back('{d: v.e, m: v.m});
  endtask
  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin tick(); k++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask
  task automatic chk_reset_outs(input string nm);
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_out_data"}, 32'(out_data), 32'd0);
    chk({nm, "_add_a"}, 32'(add_a), 32'd0);
    chk({nm, "_add_b"}, 32'(add_b), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

`ifdef FP_ACC_FLAGS_EN
  logic f_iv = 0, f_ir, f_ov, f_or = 0, f_busy, f_nan, f_inf;
  logic [15:0] f_id = '0, f_a, f_b, f_od, f_sum;
  assign f_sum = fp_add(f_a, f_b);
  fp16_vec_accumulator #(.VEC_LEN(2), .CNT_W(5)) u_f (
    .clk(clk), .rst_n(rst_n), .in_valid(f_iv), .in_ready(f_ir), .in_data(f_id),
    .add_a(f_a), .add_b(f_b), .add_sum(f_sum), .out_valid(f_ov), .out_ready(f_or),
    .out_data(f_od), .busy(f_busy), .nan_flag(f_nan), .inf_flag(f_inf)
  );
  task automatic f_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e,
                       input logic nan_e, input logic inf_e);
    f_iv = 1; f_id = a; tick();
    f_id = b; tick(); tick();
    f_iv = 0; tick();
    @(negedge clk);
    chk("flag_out_valid", 32'(f_ov), 32'd1);
    chk("flag_out_data", 32'(f_od[14:0]), 32'(e[14:0]));
    chk("flag_nan", 32'(f_nan), 32'(nan_e));
    chk("flag_inf", 32'(f_inf), 32'(inf_e));
    f_or = 1; tick(); f_or = 0;
    @(negedge clk);
    chk("flag_nan_clr", 32'(f_nan), 32'd0);
    chk("flag_inf_clr", 32'(f_inf), 32'd0);
    tick();
  endtask
`endif

  initial begin
    vec_t tbl [5];
    vec_t one;
    int k;
    tbl[0].t = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}; tbl[0].e = 16'h4400; tbl[0].m = 16'hFFFF;
    tbl[1].t = '{16'h4000, 16'hC000, 16'h4000, 16'hC000}; tbl[1].e = 16'h0000; tbl[1].m = 16'h7FFF;
    tbl[2].t = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400}; tbl[2].e = 16'h4900; tbl[2].m = 16'hFFFF;
    tbl[3].t = '{16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00}; tbl[3].e = 16'h7C00; tbl[3].m = 16'hFFFF;
    tbl[4].t = '{16'h3C00, 16'hBC00, 16'h3800, 16'h3800}; tbl[4].e = 16'h3C00; tbl[4].m = 16'hFFFF;
    one = tbl[0];
    repeat (2) tick();
    chk_reset_outs("reset");
    rst_n = 1;
    tick();
    // back-to-back terms with out_ready high: check handshake cadence and 2-cycle latency
    out_ready = 1; in_valid = 1; in_data = 16'h3C00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("cadence_in_ready_%0d", i), 32'(in_ready),
          32'(i < 8 ? (i % 2 == 0) : (i == 9)));
      chk($sformatf("cadence_out_valid_%0d", i), 32'(out_valid), 32'(i == 8));
      if (i == 6) sb.push_back('{d: 16'h4400, m: 16'hFFFF});
      tick();
      if (i == 6) in_valid = 0;
    end
    drain();
    foreach (tbl[i]) begin
      send_vec(tbl[i], 0);
      drain();
    end
    // backpressure: result held, no term consumed
    out_ready = 0;
    send_vec(one, 0);
    in_valid = 1; in_data = 16'h3C00;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("bp_wait", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_data", 32'(out_data), 32'h4400);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1; in_valid = 0;
    drain();
    send_vec(one, 0);
    drain();
    // reset discards a partial sum
    send(16'h3C00, 0);
    send(16'h3C00, 0);
    tick();
    @(negedge clk);
    chk("partial_busy", 32'(busy), 32'd1);
    rst_n = 0;
    tick();
    chk_reset_outs("mid_reset");
    rst_n = 1;
    tick();
    send_vec(one, 0);
    drain();
    // random bubbles keep the result and the latency
    for (int r = 0; r < 3; r++) begin
      send_vec(one, 3);
      @(negedge clk);
      chk("bubble_lat_add", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("bubble_lat_out", 32'(out_valid), 32'd1);
      tick();
      drain();
    end
`ifdef FP_ACC_FLAGS_EN
    f_vec(16'h7C00, 16'h3C00, 16'h7C00, 1'b0, 1'b1);
    f_vec(16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0);
    f_vec(16'h7E00, 16'h3C00, 16'h7E00, 1'b1, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
